pcecd_cmd_collector: RTL

//  SCSI command-phase byte collector for the PCE CD drive target. Sits beside the drive phase FSM:

---
 rtl/pcecd_pkg.sv | 45 ++++
 rtl/pcecd_cdb_len_lut.sv | 29 ++
 rtl/pcecd_cmd_collector.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pcecd_pkg.sv
// Shared definitions for the PCE CD drive target: bus phases, SCSI opcodes,
// CDB length constants and the command collector state encoding.
package pcecd_pkg;

  localparam int CDB_MAX_BYTES = 10;
  localparam int CDB_DB_WIDTH  = 8;
  localparam int CDB_CNT_W     = 4;

  typedef enum logic [2:0] {
    PHASE_BUS_FREE    = 3'd0,
    PHASE_COMMAND     = 3'd1,
    PHASE_DATA_IN     = 3'd2,
    PHASE_DATA_OUT    = 3'd3,
    PHASE_STATUS      = 3'd4,
    PHASE_MESSAGE_IN  = 3'd5,
    PHASE_MESSAGE_OUT = 3'd6
  } phase_e;

  // Group 0 (6-byte) commands understood by the drive
  localparam logic [7:0] OP_TEST_UNIT_READY = 8'h00;
  localparam logic [7:0] OP_REQUEST_SENSE   = 8'h03;
  localparam logic [7:0] OP_READ6           = 8'h08;
  localparam logic [7:0] OP_INQUIRY         = 8'h12;
  localparam logic [7:0] OP_MODE_SELECT6    = 8'h15;
  localparam logic [7:0] OP_MODE_SENSE6     = 8'h1A;

  // Vendor-specific (10-byte) audio and TOC commands
  localparam logic [7:0] OP_AUDIO_START_POS = 8'hD8;
  localparam logic [7:0] OP_AUDIO_END_POS   = 8'hD9;
  localparam logic [7:0] OP_AUDIO_PAUSE     = 8'hDA;
  localparam logic [7:0] OP_READ_SUBCODE_Q  = 8'hDD;
  localparam logic [7:0] OP_GET_DIR_INFO    = 8'hDE;

  localparam logic [CDB_CNT_W-1:0] CDB_LEN_6       = 4'd6;
  localparam logic [CDB_CNT_W-1:0] CDB_LEN_10      = 4'd10;
  localparam logic [CDB_CNT_W-1:0] CDB_LEN_ILLEGAL = 4'd1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LATCH   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } coll_state_e;

endpackage

// File: rtl/pcecd_cdb_len_lut.sv
// Opcode to CDB length decoder; unknown opcodes map to a 1-byte illegal CDB.
module pcecd_cdb_len_lut
  import pcecd_pkg::*;
(
  input  logic [7:0]           opcode,
  output logic [CDB_CNT_W-1:0] len,
  output logic                 illegal
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    len     = CDB_LEN_ILLEGAL;
    illegal = 1'b1;
    case (opcode)
      OP_TEST_UNIT_READY, OP_REQUEST_SENSE, OP_READ6,
      OP_INQUIRY, OP_MODE_SELECT6, OP_MODE_SENSE6: begin
        len     = CDB_LEN_6;
        illegal = 1'b0;
      end
      OP_AUDIO_START_POS, OP_AUDIO_END_POS, OP_AUDIO_PAUSE,
      OP_READ_SUBCODE_Q, OP_GET_DIR_INFO: begin
        len     = CDB_LEN_10;
        illegal = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pcecd_cmd_collector.sv
// SCSI command-phase byte collector: captures CDB bytes on REQ/ACK handshakes,
// asks the phase FSM to drop/raise REQ and presents the finished CDB.
module pcecd_cmd_collector
  import pcecd_pkg::*;
#(
  parameter int MAX_CDB_BYTES = CDB_MAX_BYTES,
  parameter int DB_WIDTH      = CDB_DB_WIDTH
)
(
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_cmd_phase,
  input  logic                              i_req,
  input  logic                              i_ack,
  input  logic [DB_WIDTH-1:0]               i_db,
  input  logic                              i_cmd_taken,
  output logic                              o_req_clr,
  output logic                              o_req_set,
  output logic                              o_cmd_valid,
  output logic                              o_cmd_illegal,
  output logic [CDB_CNT_W-1:0]              o_cmd_len,
  output logic [MAX_CDB_BYTES*DB_WIDTH-1:0] o_cdb,
  output logic                              o_abort,
  output logic                              o_overrun
);

  localparam logic [CDB_CNT_W-1:0] MAX_CNT = CDB_CNT_W'(MAX_CDB_BYTES);

  coll_state_e state, state_next;

  logic [CDB_CNT_W-1:0]              count;
  logic [CDB_CNT_W-1:0]              len_q;
  logic                              illegal_q;
  logic [MAX_CDB_BYTES*DB_WIDTH-1:0] cdb_q;
  logic                              armed;
  logic                              hs_used;
  logic                              overrun_q;

  logic                 hs, hs_new, released;
  logic                 capture, drop, want_next, complete;
  logic [CDB_CNT_W-1:0] lut_len;
  logic                 lut_illegal;

  pcecd_cdb_len_lut u_len_lut (
    .opcode  (cdb_q[7:0]),
    .len     (lut_len),
    .illegal (lut_illegal)
  );

  // hs_used marks a REQ&&ACK level already consumed, so a held level yields one byte.
  assign hs       = i_req && i_ack;
  assign hs_new   = hs && !hs_used;
  assign released = !i_req && !i_ack;

  assign capture   = i_cmd_phase && hs_new &&
                     ((state == ST_IDLE) ||
                      (state == ST_RELEASE && armed && count != MAX_CNT));
  assign drop      = hs_new && (count == MAX_CNT) &&
                     (state == ST_RELEASE || state == ST_DONE);
  assign want_next = (state == ST_RELEASE) && i_cmd_phase && !armed &&
                     released && (count != len_q);
  assign complete  = (state == ST_RELEASE) && i_cmd_phase && !armed &&
                     released && (count == len_q);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (capture) state_next = ST_LATCH;
      ST_LATCH:   state_next = i_cmd_phase ? ST_RELEASE : ST_IDLE;
      ST_RELEASE: begin
        if (!i_cmd_phase)  state_next = ST_IDLE;
        else if (capture)  state_next = ST_LATCH;
        else if (complete) state_next = ST_DONE;
      end
      ST_DONE:    if (i_cmd_taken) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_req_clr   = 1'b0;
    o_req_set   = 1'b0;
    o_abort     = 1'b0;
    o_cmd_valid = 1'b0;
    case (state)
      ST_LATCH: begin
        if (i_cmd_phase) o_req_clr = 1'b1;
        else             o_abort   = 1'b1;
      end
      ST_RELEASE: begin
        if (!i_cmd_phase) o_abort   = 1'b1;
        else              o_req_set = want_next;
      end
      ST_DONE:  o_cmd_valid = 1'b1;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the CDB store is cleared on reset because o_cdb is a visible output defined as zero after reset.
      cdb_q     <= '0;
      count     <= '0;
      len_q     <= '0;
      illegal_q <= 1'b0;
      armed     <= 1'b0;
      hs_used   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      hs_used <= hs && (hs_used || capture || drop);

      if (capture) cdb_q[int'(count)*DB_WIDTH +: DB_WIDTH] <= i_db;

      if (capture || o_abort) armed <= 1'b0;
      else if (want_next)     armed <= 1'b1;

      if (o_abort || (state == ST_DONE && i_cmd_taken))
        count <= '0;
      else if (state == ST_LATCH && count != MAX_CNT)
        count <= count + 4'd1;

      // Length is decoded once, in the cycle after the opcode byte lands.
      if (state == ST_LATCH && i_cmd_phase && count == '0) begin
        len_q     <= lut_len;
        illegal_q <= lut_illegal;
      end

      if (drop) overrun_q <= 1'b1;
    end
  end

  assign o_cmd_illegal = illegal_q;
  assign o_cmd_len     = len_q;
  assign o_cdb         = cdb_q;
  assign o_overrun     = overrun_q;

endmodule
